// File: rtl/conware_pkg.sv
// Shared definitions for the conware pixel pipeline: handshake state
// encoding, counter width, error-bit positions and the sticky-error update.
package conware_pkg;

  // Row cell counter width; supports rows of up to 256 cells.
  localparam int CNT_W = 8;

  // Two-state handshake encoding. The serializer downstream reuses the same
  // codes under its own names (Wait/Write), so both blocks stay in step.
  typedef logic [0:0] state_t;
  localparam state_t FILL      = 1'b0;
  localparam state_t EMIT      = 1'b1;
  localparam state_t SER_WAIT  = FILL;
  localparam state_t SER_WRITE = EMIT;

  // frame_err bit positions.
  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;

  // Sticky error update: newly set bits always survive, clear only removes
  // bits that are not being set in the same cycle.
  function automatic logic [1:0] err_next(input logic [1:0] err_q,
                                          input logic [1:0] set_s,
                                          input logic       clr);
    return set_s | (clr ? 2'b00 : err_q);
  endfunction

endpackage

// File: rtl/axis2buffer_if.sv
// Bus bundle for axis2buffer: AXI4-Stream pixel input plus the packed-row
// valid/ready output. "master" is the environment side, "slave" the block.
interface axis2buffer_if #(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 4
) ();

  logic [DWIDTH-1:0] S_AXIS_TDATA;
  logic              S_AXIS_TVALID;
  logic              S_AXIS_TREADY;
  logic              S_AXIS_TLAST;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, out_ready,
    input  S_AXIS_TREADY, out_data, out_valid
  );

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, out_ready,
    output S_AXIS_TREADY, out_data, out_valid
  );

endinterface

// File: rtl/axis2buffer.sv
// axis2buffer: classifies incoming pixels as alive/dead, packs WIDTH of them
// into one row word and hands the row downstream. TLAST misalignment with the
// row boundary is reported through sticky frame_err bits.
module axis2buffer
  import conware_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DWIDTH-1:0] alive_color,
  input  logic              clr_err,
  output logic [1:0]        frame_err,
  axis2buffer_if.slave      s
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] row_q, row_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       err_q, err_d;

  logic             tready_s;
  logic             valid_s;
  logic             beat_s;
  logic             pix_s;
  logic             last_pos_s;
  logic             done_s;
  logic [1:0]       set_s;
  logic [WIDTH-1:0] row_new_s;

  assign beat_s     = s.S_AXIS_TVALID & tready_s;
  assign pix_s      = (s.S_AXIS_TDATA == alive_color);
  assign last_pos_s = (cnt_q == CNT_W'(WIDTH - 1));
  assign done_s     = beat_s & (last_pos_s | s.S_AXIS_TLAST);

  // Error events, only on a completing beat: early TLAST or missing TLAST.
  always_comb begin
    set_s            = 2'b00;
    set_s[ERR_SHORT] = done_s & s.S_AXIS_TLAST & ~last_pos_s;
    set_s[ERR_LONG]  = done_s & last_pos_s & ~s.S_AXIS_TLAST;
  end

  // Current row with this beat's cell merged in at the counter position.
  always_comb begin
    row_new_s = row_q;
    for (int k = 0; k < WIDTH; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        row_new_s[k] = pix_s;
      end else begin
        row_new_s[k] = row_q[k];
      end
    end
  end

  // Packer next state: advance on a beat, publish and restart on completion.
  always_comb begin
    cnt_d  = cnt_q;
    row_d  = row_q;
    data_d = data_q;
    if (done_s) begin
      cnt_d  = {CNT_W{1'b0}};
      row_d  = {WIDTH{1'b0}};
      data_d = row_new_s;
    end else if (beat_s) begin
      cnt_d  = cnt_q + CNT_W'(1);
      row_d  = row_new_s;
    end else begin
      cnt_d  = cnt_q;
      row_d  = row_q;
    end
    err_d = err_next(err_q, set_s, clr_err);
  end

  // FSM next state: Fill until a row completes, Emit until downstream takes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (done_s) state_d = EMIT;
        else        state_d = FILL;
      end
      EMIT: begin
        if (s.out_ready) state_d = FILL;
        else             state_d = EMIT;
      end
      default: state_d = FILL;
    endcase
  end

  // FSM outputs; TREADY is also forced low while reset is held.
  always_comb begin
    tready_s = 1'b0;
    valid_s  = 1'b0;
    case (state_q)
      FILL:    tready_s = rstn;
      EMIT:    valid_s  = 1'b1;
      default: begin
        tready_s = 1'b0;
        valid_s  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Packer, output row and sticky error registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= {CNT_W{1'b0}};
      row_q  <= {WIDTH{1'b0}};
      data_q <= {WIDTH{1'b0}};
      err_q  <= 2'b00;
    end else begin
      cnt_q  <= cnt_d;
      row_q  <= row_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign s.S_AXIS_TREADY = tready_s;
  assign s.out_valid     = valid_s;
  assign s.out_data      = data_q;
  assign frame_err       = err_q;

endmodule
